// File: rtl/pueo_trig_pkg.sv
// Shared constants for the PUEO trigger collector: output word field
// offsets, SURF hit-flag position and auxiliary source indices.
package pueo_trig_pkg;

  localparam int unsigned AUX_SOFT = 0;
  localparam int unsigned AUX_PPS  = 1;
  localparam int unsigned AUX_EXT  = 2;

  // Candidate word is {aux_hit, surf_hit, time}, time in the LSBs.
  function automatic int unsigned time_lsb();
    return 0;
  endfunction

  function automatic int unsigned surf_lsb(input int unsigned time_bits);
    return time_bits;
  endfunction

  function automatic int unsigned aux_lsb(input int unsigned nsurf, input int unsigned time_bits);
    return nsurf + time_bits;
  endfunction

  function automatic int unsigned hit_bit(input int unsigned nbit);
    return nbit - 1;
  endfunction

endpackage

// File: rtl/pueo_trig_collector_fifo.sv
// Synchronous first-word-fall-through FIFO for trigger candidates.
// Push and pop together at full is legal: the popped slot takes the new word.
module trig_cand_fifo #(
  parameter int unsigned WIDTH = 67,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic             do_push, do_pop;

  always_comb begin
    empty_o = (wr_q == rd_q);
    full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_pop  = pop_i & ~empty_o;
    do_push = push_i & (~full_o | do_pop);
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = do_pop  ? rd_q + 1'b1 : rd_q;
    rdata_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/pueo_trig_collector.sv
// Merges masked SURF trigger beats with offset-corrected aux pulses, applies
// holdoff and queues timestamped candidates onto an AXI4-S stream.
module pueo_trig_collector
  import pueo_trig_pkg::*;
#(
  parameter int unsigned NSURF       = 32,
  parameter int unsigned NBIT        = 16,
  parameter int unsigned NAUX        = 3,
  parameter int unsigned TIME_BITS   = 32,
  parameter int unsigned OFFSET_BITS = 16,
  parameter int unsigned FIFO_DEPTH  = 16,
  localparam int unsigned OUTW       = NAUX + NSURF + TIME_BITS
) (
  input  logic                        sysclk_i,
  input  logic                        rst_i,
  input  logic                        run_en_i,
  input  logic [NSURF*NBIT-1:0]       trig_dat_i,
  input  logic                        trig_dat_valid_i,
  input  logic [NSURF-1:0]            trigmask_i,
  input  logic [NAUX-1:0]             aux_trig_i,
  input  logic [NAUX-1:0]             aux_en_i,
  input  logic [NAUX*OFFSET_BITS-1:0] aux_offset_i,
  input  logic [TIME_BITS-1:0]        cur_time_i,
  input  logic [15:0]                 holdoff_i,
  output logic [OUTW-1:0]             trig_tdata,
  output logic                        trig_tvalid,
  input  logic                        trig_tready,
  output logic                        overflow_o,
  output logic [15:0]                 dropped_o,
  output logic [31:0]                 accepted_o
);

  localparam int unsigned TIME_LSB = time_lsb();
  localparam int unsigned SURF_LSB = surf_lsb(TIME_BITS);
  localparam int unsigned AUX_LSB  = aux_lsb(NSURF, TIME_BITS);
  localparam int unsigned HIT_BIT  = hit_bit(NBIT);

  logic                 flush_q, flush_d;
  logic [NSURF-1:0]     surf_hit_q, surf_hit_d;
  logic [TIME_BITS-1:0] beat_time_q, beat_time_d;
  logic [NAUX-1:0]      aux_pend_q, aux_pend_d, aux_keep;
  logic [TIME_BITS-1:0] aux_time_q [NAUX];
  logic [TIME_BITS-1:0] aux_time_d [NAUX];
  logic                 cand_vld_q, cand_vld_d;
  logic [OUTW-1:0]      cand_dat_q, cand_dat_d;
  logic [TIME_BITS-1:0] cand_time;
  logic                 aux_found;
  logic [15:0]          hold_q, hold_d, dropped_q, dropped_d;
  logic [31:0]          accepted_q, accepted_d;
  logic                 overflow_q, overflow_d;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic                 unused_dat;

  // Only the hit flag of each SURF word is consumed.
  assign unused_dat = ^trig_dat_i;

  always_comb begin
    flush_d     = trig_dat_valid_i;
    surf_hit_d  = surf_hit_q;
    beat_time_d = beat_time_q;
    if (trig_dat_valid_i) begin
      beat_time_d = cur_time_i;
      for (int unsigned k = 0; k < NSURF; k++)
        surf_hit_d[k] = trig_dat_i[k*NBIT + HIT_BIT] & ~trigmask_i[k];
    end

    // The flush cycle clears the window; a pulse on it opens the next one.
    aux_keep = flush_q ? '0 : aux_pend_q;
    for (int unsigned i = 0; i < NAUX; i++) begin
      aux_pend_d[i] = aux_keep[i];
      aux_time_d[i] = aux_time_q[i];
      if (aux_trig_i[i] & aux_en_i[i] & ~aux_keep[i]) begin
        aux_pend_d[i] = 1'b1;
        aux_time_d[i] = cur_time_i - TIME_BITS'(aux_offset_i[i*OFFSET_BITS +: OFFSET_BITS]);
      end
    end

    cand_time = '0;
    aux_found = 1'b0;
    for (int unsigned i = 0; i < NAUX; i++) begin
      if (aux_pend_q[i] && !aux_found) begin
        cand_time = aux_time_q[i];
        aux_found = 1'b1;
      end
    end
    if (|surf_hit_q) cand_time = beat_time_q;

    cand_vld_d = flush_q & run_en_i & ((|surf_hit_q) | (|aux_pend_q));
    cand_dat_d = '0;
    cand_dat_d[TIME_LSB +: TIME_BITS] = cand_time;
    cand_dat_d[SURF_LSB +: NSURF]     = surf_hit_q;
    cand_dat_d[AUX_LSB +: NAUX]       = aux_pend_q;

    fifo_pop   = trig_tvalid & trig_tready;
    fifo_push  = 1'b0;
    hold_d     = (hold_q != '0) ? hold_q - 16'd1 : hold_q;
    dropped_d  = dropped_q;
    accepted_d = accepted_q;
    overflow_d = overflow_q;
    if (cand_vld_q) begin
      if (hold_q != '0) begin
        if (dropped_q != '1) dropped_d = dropped_q + 16'd1;
      end else if (fifo_full & ~fifo_pop) begin
        overflow_d = 1'b1;
      end else begin
        fifo_push  = 1'b1;
        accepted_d = accepted_q + 32'd1;
        hold_d     = holdoff_i;
      end
    end
  end

  always_ff @(posedge sysclk_i) begin
    if (rst_i) begin
      flush_q     <= 1'b0;
      surf_hit_q  <= '0;
      beat_time_q <= '0;
      aux_pend_q  <= '0;
      for (int unsigned i = 0; i < NAUX; i++) aux_time_q[i] <= '0;
      cand_vld_q  <= 1'b0;
      cand_dat_q  <= '0;
      hold_q      <= '0;
      dropped_q   <= '0;
      accepted_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      flush_q     <= flush_d;
      surf_hit_q  <= surf_hit_d;
      beat_time_q <= beat_time_d;
      aux_pend_q  <= aux_pend_d;
      for (int unsigned i = 0; i < NAUX; i++) aux_time_q[i] <= aux_time_d[i];
      cand_vld_q  <= cand_vld_d;
      cand_dat_q  <= cand_dat_d;
      hold_q      <= hold_d;
      dropped_q   <= dropped_d;
      accepted_q  <= accepted_d;
      overflow_q  <= overflow_d;
    end
  end

  trig_cand_fifo #(
    .WIDTH (OUTW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (sysclk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .wdata_i (cand_dat_q),
    .pop_i   (fifo_pop),
    .rdata_o (trig_tdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign trig_tvalid = ~fifo_empty;
  assign overflow_o  = overflow_q;
  assign dropped_o   = dropped_q;
  assign accepted_o  = accepted_q;

endmodule

// File: tb/tb_pueo_trig_collector.sv
// Directed bench for pueo_trig_collector with an expected-word scoreboard.
module tb_pueo_trig_collector;
  import pueo_trig_pkg::*;

  localparam int unsigned NSURF = 32, NBIT = 16, NAUX = 3, TIME_BITS = 32, OFFSET_BITS = 16;
  localparam int unsigned OUTW = NAUX + NSURF + TIME_BITS;

  logic                        sysclk_i = 1'b0;
  logic                        rst_i = 1'b1;
  logic                        run_en_i = 1'b1;
  logic [NSURF*NBIT-1:0]       trig_dat_i = '0;
  logic                        trig_dat_valid_i = 1'b0;
  logic [NSURF-1:0]            trigmask_i = '0;
  logic [NAUX-1:0]             aux_trig_i = '0;
  logic [NAUX-1:0]             aux_en_i = '1;
  logic [NAUX*OFFSET_BITS-1:0] aux_offset_i = '0;
  logic [TIME_BITS-1:0]        cur_time_i = '0;
  logic [15:0]                 holdoff_i = '0;
  logic [OUTW-1:0]             trig_tdata;
  logic                        trig_tvalid;
  logic                        trig_tready = 1'b1;
  logic                        overflow_o;
  logic [15:0]                 dropped_o;
  logic [31:0]                 accepted_o;

  pueo_trig_collector dut (
    .sysclk_i         (sysclk_i),
    .rst_i            (rst_i),
    .run_en_i         (run_en_i),
    .trig_dat_i       (trig_dat_i),
    .trig_dat_valid_i (trig_dat_valid_i),
    .trigmask_i       (trigmask_i),
    .aux_trig_i       (aux_trig_i),
    .aux_en_i         (aux_en_i),
    .aux_offset_i     (aux_offset_i),
    .cur_time_i       (cur_time_i),
    .holdoff_i        (holdoff_i),
    .trig_tdata       (trig_tdata),
    .trig_tvalid      (trig_tvalid),
    .trig_tready      (trig_tready),
    .overflow_o       (overflow_o),
    .dropped_o        (dropped_o),
    .accepted_o       (accepted_o)
  );

  always #5 sysclk_i = ~sysclk_i;

  int unsigned     errors = 0, checks = 0, exp_acc = 0;
  logic [OUTW-1:0] exp_q [$];
  logic            last_tvalid = 1'b0, stalled = 1'b0;
  logic [OUTW-1:0] stall_dat = '0;
  logic [31:0]     wrap_t;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OUTW-1:0] mk(input logic [NAUX-1:0] a, input logic [NSURF-1:0] s,
                                         input logic [TIME_BITS-1:0] t);
    return {a, s, t};
  endfunction

  function automatic logic [NSURF*NBIT-1:0] sw(input int unsigned k, input logic [NBIT-1:0] w);
    logic [NSURF*NBIT-1:0] r;
    r = '0;
    r[k*NBIT +: NBIT] = w;
    return r;
  endfunction

  task automatic expect_word(input logic [OUTW-1:0] w);
    exp_q.push_back(w);
    exp_acc++;
  endtask

  // Outputs are sampled on the falling edge; inputs change 1 ns after the rising edge.
  task automatic tick();
    logic [OUTW-1:0] e;
    @(negedge sysclk_i);
    last_tvalid = trig_tvalid;
    if (stalled && trig_tvalid) check("tdata_stable", trig_tdata, stall_dat);
    if (trig_tvalid && trig_tready) begin
      if (exp_q.size() == 0) check("unexpected_tvalid", trig_tvalid, 1'b0);
      else begin
        e = exp_q.pop_front();
        check("tdata", trig_tdata, e);
      end
    end
    stalled   = trig_tvalid & ~trig_tready;
    stall_dat = trig_tdata;
    @(posedge sysclk_i);
    #1;
    cur_time_i = cur_time_i + 1;
  endtask

  task automatic cyc(input logic v, input logic [NSURF*NBIT-1:0] d, input logic [NAUX-1:0] a);
    trig_dat_valid_i = v;
    trig_dat_i       = d;
    aux_trig_i       = a;
    tick();
    trig_dat_valid_i = 1'b0;
    trig_dat_i       = '0;
    aux_trig_i       = '0;
  endtask

  task automatic beat(input logic [NSURF*NBIT-1:0] d);
    cyc(1'b1, d, '0);
    repeat (3) tick();
  endtask

  task automatic drain(input int unsigned budget);
    for (int unsigned i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    repeat (4) tick();
    check("drain_empty", 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_tvalid", trig_tvalid, 1'b0);
    check("rst_tdata", trig_tdata, '0);
    check("rst_overflow", overflow_o, 1'b0);
    check("rst_dropped", dropped_o, 16'd0);
    check("rst_accepted", accepted_o, 32'd0);
    rst_i = 1'b0;
    tick();

    // SURF0 hit, tvalid exactly three cycles after the beat
    trigmask_i = 32'hFFFF_FFFE;
    cur_time_i = 500;
    expect_word(mk('0, 32'h1, 32'd500));
    cyc(1'b1, sw(0, 16'h8010), '0);
    tick();
    tick();
    check("latency_n2_idle", last_tvalid, 1'b0);
    tick();
    check("latency_n3_valid", last_tvalid, 1'b1);
    drain(10);
    check("accepted_1", accepted_o, 32'd1);

    // Masked SURF1 hit and a SURF0 word without its hit flag
    beat(sw(1, 16'h8000));
    beat(sw(0, 16'h00AA));
    repeat (4) tick();
    check("masked_accepted", accepted_o, 32'd1);
    check("masked_dropped", dropped_o, 16'd0);

    // Aux only: first pulse captured, second pulse in the window ignored
    aux_offset_i[AUX_SOFT*OFFSET_BITS +: OFFSET_BITS] = 16'd100;
    aux_offset_i[AUX_PPS*OFFSET_BITS +: OFFSET_BITS]  = 16'd50000;
    aux_offset_i[AUX_EXT*OFFSET_BITS +: OFFSET_BITS]  = 16'd7;
    cur_time_i = 1000;
    expect_word(mk(3'(1 << AUX_SOFT), '0, 32'd900));
    cyc(1'b0, '0, 3'(1 << AUX_SOFT));
    cyc(1'b0, '0, 3'(1 << AUX_SOFT));
    beat('0);
    drain(10);
    // Offset larger than the capture time wraps
    wrap_t = 32'd20 - 32'd50000;
    cur_time_i = 20;
    expect_word(mk(3'(1 << AUX_PPS), '0, wrap_t));
    cyc(1'b0, '0, 3'(1 << AUX_PPS));
    beat('0);
    drain(10);
    // Disabled aux produces nothing
    aux_en_i = 3'b011;
    cyc(1'b0, '0, 3'(1 << AUX_EXT));
    beat('0);
    repeat (4) tick();
    aux_en_i = '1;

    // SURF hit + aux2 in the same window; aux0 on the flush cycle goes to the next window
    cur_time_i = 2000;
    expect_word(mk(3'(1 << AUX_EXT), 32'h1, 32'd2000));
    expect_word(mk(3'(1 << AUX_SOFT), '0, 32'd2900));
    cyc(1'b1, sw(0, 16'h8000), 3'(1 << AUX_EXT));
    cur_time_i = 3000;
    cyc(1'b0, '0, 3'(1 << AUX_SOFT));
    tick();
    tick();
    beat('0);
    drain(10);
    check("accepted_5", accepted_o, 32'(exp_acc));

    // Holdoff: second hit 8 cycles later dropped, hit 204 cycles after the first accepted
    holdoff_i = 16'd200;
    cur_time_i = 5000;
    expect_word(mk('0, 32'h1, 32'd5000));
    beat(sw(0, 16'h8000));
    beat('0);
    beat(sw(0, 16'h8000));
    repeat (48) beat('0);
    cur_time_i = 6000;
    expect_word(mk('0, 32'h1, 32'd6000));
    beat(sw(0, 16'h8000));
    drain(10);
    check("holdoff_dropped", dropped_o, 16'd1);
    check("holdoff_accepted", accepted_o, 32'(exp_acc));
    holdoff_i = 16'd0;
    repeat (53) beat('0);

    // run_en low forms no candidates
    run_en_i = 1'b0;
    beat(sw(0, 16'h8000));
    repeat (4) tick();
    run_en_i = 1'b1;
    check("runen_accepted", accepted_o, 32'(exp_acc));

    // Backpressure: 17 hits, 16 queued, overflow on the last
    trig_tready = 1'b0;
    for (int unsigned i = 0; i < 17; i++) begin
      cur_time_i = 32'(7000 + i);
      if (i < 16) expect_word(mk('0, 32'h1, 32'(7000 + i)));
      beat(sw(0, 16'h8000));
    end
    repeat (4) tick();
    check("bp_overflow", overflow_o, 1'b1);
    check("bp_accepted", accepted_o, 32'(exp_acc));
    check("bp_tvalid", trig_tvalid, 1'b1);
    trig_tready = 1'b1;
    drain(40);
    check("bp_overflow_sticky", overflow_o, 1'b1);

    // Reset in the middle of a drain
    trig_tready = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      cur_time_i = 32'(9000 + i);
      expect_word(mk('0, 32'h1, 32'(9000 + i)));
      beat(sw(0, 16'h8000));
    end
    trig_tready = 1'b1;
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    exp_q.delete();
    tick();
    check("midrst_tvalid", last_tvalid, 1'b0);
    check("midrst_tdata", trig_tdata, '0);
    check("midrst_overflow", overflow_o, 1'b0);
    check("midrst_dropped", dropped_o, 16'd0);
    check("midrst_accepted", accepted_o, 32'd0);
    rst_i = 1'b0;
    repeat (6) tick();
    check("post_rst_tvalid", last_tvalid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
